// File: rtl/unified_mem_arbiter.sv
// Fetch/data arbiter for the single-ported unified memory. Data has priority over fetch.
// Define ARB_STARVE_GUARD_EN to force a fetch grant after STARVE_MAX back-to-back data grants.
module unified_mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ready,
  output logic [1:0]    owner
);

  typedef enum logic [1:0] {IDLE, MEM_I, MEM_D, RESP} state_t;

  localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

  state_t        state_q, state_d;
  logic [1:0]    owner_q, owner_d;
  logic          m_req_q, m_req_d;
  logic          m_we_q, m_we_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [DW-1:0] m_wdata_q, m_wdata_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          i_ack_q, i_ack_d;
  logic          d_ack_q, d_ack_d;
  logic          force_fetch;
  logic          grant_d;
  logic          grant_i;

`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] starve_q, starve_d;

  assign force_fetch = i_req && (starve_q == STARVE_LIMIT);

  // Counts data grants that bypassed a waiting fetch; any fetch grant or idle fetch port clears it.
  always_comb begin
    starve_d = starve_q;
    if (state_q == IDLE && (i_req || d_req)) begin
      if (grant_i || !i_req) starve_d = 4'd0;
      else if (grant_d)      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) starve_q <= 4'd0;
    else     starve_q <= starve_d;
  end
`else
  logic unused_starve_limit;

  assign force_fetch         = 1'b0;
  assign unused_starve_limit = ^STARVE_LIMIT;
`endif

  assign grant_d = (state_q == IDLE) && d_req && !force_fetch;
  assign grant_i = (state_q == IDLE) && i_req && !grant_d;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d   = MEM_D;
          owner_d   = 2'b10;
          m_req_d   = 1'b1;
          m_we_d    = d_we;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
        end else if (grant_i) begin
          state_d  = MEM_I;
          owner_d  = 2'b01;
          m_req_d  = 1'b1;
          m_we_d   = 1'b0;
          m_addr_d = i_addr;
        end
      end
      MEM_I, MEM_D: begin
        if (m_ready) begin
          state_d = RESP;
          m_req_d = 1'b0;
          m_we_d  = 1'b0;
          if (state_q == MEM_I) begin
            i_rdata_d = m_rdata;
            i_ack_d   = 1'b1;
          end else begin
            d_ack_d = 1'b1;
            // Stores must leave the last load result intact.
            if (!m_we_q) d_rdata_d = m_rdata;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
        owner_d = 2'b00;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= 2'b00;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
    end
  end

  assign owner   = owner_q;
  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign i_ack   = i_ack_q;
  assign d_ack   = d_ack_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: a memory responder with programmable wait
// returns base^addr; expected acks are queued at request time and popped on each ack.
module tb_unified_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_ack;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ack;
  logic          m_req;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;
  logic          m_ready;
  logic [1:0]    owner;

  typedef struct {
    bit            is_fetch;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  int            n_vec = 0;
  int            n_err = 0;
  bit            mem_en = 1'b1;
  int            mem_wait = 0;
  int            wait_cnt = 0;
  logic [DW-1:0] mem_base = '0;
  logic [DW-1:0] exp_d_rdata = '0;
  logic [DW-1:0] exp_i_rdata = '0;

  unified_mem_arbiter dut (
    .clk     (clk),
    .rst     (rst),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_rdata (i_rdata),
    .i_ack   (i_ack),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_rdata (d_rdata),
    .d_ack   (d_ack),
    .m_req   (m_req),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata),
    .m_ready (m_ready),
    .owner   (owner)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory model: raises m_ready after mem_wait stall cycles of an active m_req.
  initial begin
    m_ready = 1'b0;
    m_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_en) begin
        if (m_req === 1'b1 && !m_ready) begin
          if (wait_cnt == mem_wait) begin
            m_ready  = 1'b1;
            m_rdata  = mem_base ^ m_addr;
            wait_cnt = 0;
          end else begin
            wait_cnt++;
          end
        end else begin
          m_ready  = 1'b0;
          wait_cnt = 0;
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0;
    repeat (3) tick();
    n_vec++;
    if ({owner, m_req, m_we, i_ack, d_ack} !== 6'b0) begin
      n_err++;
      $display("[TB] FAIL reset_ctrl: got %b expected 000000", {owner, m_req, m_we, i_ack, d_ack});
    end
    n_vec++;
    if ({m_addr, m_wdata} !== 64'b0) begin
      n_err++;
      $display("[TB] FAIL reset_maddr: got %h/%h expected 0/0", m_addr, m_wdata);
    end
    n_vec++;
    if ({i_rdata, d_rdata} !== 64'b0) begin
      n_err++;
      $display("[TB] FAIL reset_rdata: got %h/%h expected 0/0", i_rdata, d_rdata);
    end
    rst = 1'b0;
    tick();
    n_vec++;
    if ({owner, m_req} !== 3'b0) begin
      n_err++;
      $display("[TB] FAIL reset_idle: got %b expected 000", {owner, m_req});
    end
  endtask

  task automatic test_fetch_basic();
    exp_t e;
    mem_wait = 0;
    mem_base = 32'hDEAD_BEEF ^ 32'h0000_0010;
    i_req = 1'b1; i_addr = 32'h0000_0010;
    sb.push_back('{1'b1, 32'hDEAD_BEEF});
    tick();
    n_vec++;
    if ({m_req, owner, m_addr} !== {1'b1, 2'b01, 32'h0000_0010}) begin
      n_err++;
      $display("[TB] FAIL fetch_c1: got req=%b own=%b addr=%h expected 1/01/00000010", m_req, owner, m_addr);
    end
    tick();
    e = sb.pop_front();
    n_vec++;
    if ({i_ack, d_ack, m_req, i_rdata} !== {1'b1, 1'b0, 1'b0, e.data}) begin
      n_err++;
      $display("[TB] FAIL fetch_ack: got ia=%b da=%b mreq=%b data=%h expected 1/0/0/%h", i_ack, d_ack, m_req, i_rdata, e.data);
    end
    exp_i_rdata = e.data;
    i_req = 1'b0;
    tick();
    n_vec++;
    if ({owner, i_ack} !== 3'b0) begin
      n_err++;
      $display("[TB] FAIL fetch_c3: got own=%b ack=%b expected 00/0", owner, i_ack);
    end
  endtask

  task automatic test_load_wait();
    exp_t e;
    int   cyc;
    mem_wait = 1;
    mem_base = 32'h0BAD_0000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0200; d_wdata = 32'hFFFF_FFFF;
    sb.push_back('{1'b0, 32'h0BAD_0200});
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!d_ack && cyc < 20);
    e = sb.pop_front();
    n_vec++;
    if (cyc !== 3 || d_rdata !== e.data || i_ack !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL load_ack: got cycle=%0d data=%h ia=%b expected 3/%h/0", cyc, d_rdata, i_ack, e.data);
    end
    exp_d_rdata = e.data;
    d_req = 1'b0;
    tick();
  endtask

  task automatic test_store_wait();
    mem_wait = 3;
    mem_base = 32'h5555_0000;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0100; d_wdata = 32'h1234_5678;
    tick();
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if ({m_req, m_we, m_addr, m_wdata, d_ack, owner} !== {2'b11, 32'h0000_0100, 32'h1234_5678, 1'b0, 2'b10}) begin
        n_err++;
        $display("[TB] FAIL store_hold%0d: got req=%b we=%b addr=%h wd=%h ack=%b own=%b expected 1/1/00000100/12345678/0/10",
                 k, m_req, m_we, m_addr, m_wdata, d_ack, owner);
      end
      tick();
    end
    n_vec++;
    if ({d_ack, m_req, m_we, d_rdata} !== {3'b100, exp_d_rdata}) begin
      n_err++;
      $display("[TB] FAIL store_ack: got ack=%b req=%b we=%b rdata=%h expected 1/0/0/%h", d_ack, m_req, m_we, d_rdata, exp_d_rdata);
    end
    d_req = 1'b0; d_we = 1'b0;
    tick();
  endtask

  task automatic test_simultaneous();
    exp_t e;
    mem_wait = 0;
    mem_base = 32'hA0A0_0000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0300;
    i_req = 1'b1; i_addr = 32'h0000_0040;
    sb.push_back('{1'b0, 32'hA0A0_0300});
    sb.push_back('{1'b1, 32'hA0A0_0040});
    tick();
    n_vec++;
    if (owner !== 2'b10) begin
      n_err++;
      $display("[TB] FAIL simul_first: got owner=%b expected 10", owner);
    end
    tick();
    e = sb.pop_front();
    n_vec++;
    if ({d_ack, i_ack, d_rdata} !== {2'b10, e.data}) begin
      n_err++;
      $display("[TB] FAIL simul_dack: got da=%b ia=%b data=%h expected 1/0/%h", d_ack, i_ack, d_rdata, e.data);
    end
    exp_d_rdata = e.data;
    d_req = 1'b0;
    tick();
    tick();
    n_vec++;
    if ({owner, m_addr} !== {2'b01, 32'h0000_0040}) begin
      n_err++;
      $display("[TB] FAIL simul_fetch: got own=%b addr=%h expected 01/00000040", owner, m_addr);
    end
    tick();
    e = sb.pop_front();
    n_vec++;
    if ({i_ack, d_ack, i_rdata} !== {2'b10, e.data}) begin
      n_err++;
      $display("[TB] FAIL simul_iack: got ia=%b da=%b data=%h expected 1/0/%h", i_ack, d_ack, i_rdata, e.data);
    end
    exp_i_rdata = e.data;
    i_req = 1'b0;
    tick();
  endtask

  task automatic test_starvation();
    exp_t e;
    int   acks;
    int   cyc;
    mem_wait = 0;
    mem_base = 32'h3C3C_0000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0500;
    i_req = 1'b1; i_addr = 32'h0000_0600;
    for (int k = 0; k < 10; k++) begin
`ifdef ARB_STARVE_GUARD_EN
      if (k % 5 == 4) sb.push_back('{1'b1, 32'h3C3C_0600});
      else            sb.push_back('{1'b0, 32'h3C3C_0500});
`else
      sb.push_back('{1'b0, 32'h3C3C_0500});
`endif
    end
    acks = 0;
    cyc  = 0;
    while (acks < 10 && cyc < 100) begin
      tick();
      cyc++;
      if (i_ack || d_ack) begin
        e = sb.pop_front();
        n_vec++;
        if ({i_ack, d_ack} !== {e.is_fetch, !e.is_fetch} ||
            (e.is_fetch ? i_rdata : d_rdata) !== e.data) begin
          n_err++;
          $display("[TB] FAIL starve_ack%0d: got ia=%b da=%b idata=%h ddata=%h expected fetch=%b data=%h",
                   acks, i_ack, d_ack, i_rdata, d_rdata, e.is_fetch, e.data);
        end
        acks++;
        if (acks == 10) begin
          d_req = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
          i_req = 1'b0;
`endif
        end
      end
    end
    n_vec++;
    if (acks != 10) begin
      n_err++;
      $display("[TB] FAIL starve_timeout: got %0d acks expected 10", acks);
    end
`ifndef ARB_STARVE_GUARD_EN
    sb.push_back('{1'b1, 32'h3C3C_0600});
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!i_ack && cyc < 10);
    e = sb.pop_front();
    n_vec++;
    if (cyc !== 3 || i_rdata !== e.data) begin
      n_err++;
      $display("[TB] FAIL starve_release: got cycle=%0d data=%h expected 3/%h", cyc, i_rdata, e.data);
    end
    i_req = 1'b0;
`endif
    sb.delete();
    tick();
  endtask

  task automatic test_reset_mid();
    bit seen_ack;
    mem_wait = 100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0400;
    tick();
    n_vec++;
    if ({m_req, owner} !== 3'b110) begin
      n_err++;
      $display("[TB] FAIL rstmid_busy: got req=%b own=%b expected 1/10", m_req, owner);
    end
    rst = 1'b1;
    d_req = 1'b0;
    tick();
    rst = 1'b0;
    exp_d_rdata = '0;
    exp_i_rdata = '0;
    n_vec++;
    if ({m_req, owner, d_ack, d_rdata} !== {4'b0000, 32'h0}) begin
      n_err++;
      $display("[TB] FAIL rstmid_abort: got req=%b own=%b ack=%b rdata=%h expected 0/00/0/0", m_req, owner, d_ack, d_rdata);
    end
    seen_ack = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (d_ack || i_ack || m_req) seen_ack = 1'b1;
    end
    n_vec++;
    if (seen_ack !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL rstmid_noack: got activity=%b expected 0", seen_ack);
    end
    mem_wait = 0;
  endtask

  task automatic test_idle_ready();
    mem_en = 1'b0;
    m_ready = 1'b1;
    m_rdata = 32'hCAFE_F00D;
    tick();
    m_ready = 1'b0;
    tick();
    n_vec++;
    if ({owner, m_req, i_ack, d_ack, i_rdata, d_rdata} !== {5'b0, exp_i_rdata, exp_d_rdata}) begin
      n_err++;
      $display("[TB] FAIL idle_ready: got own=%b req=%b ia=%b da=%b idata=%h ddata=%h expected 00/0/0/0/%h/%h",
               owner, m_req, i_ack, d_ack, i_rdata, d_rdata, exp_i_rdata, exp_d_rdata);
    end
    mem_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fetch_basic();
    test_load_wait();
    test_store_wait();
    test_simultaneous();
    test_starvation();
    test_reset_mid();
    test_idle_ready();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Arbiter and sequencer for the single-ported unified memory shared by the pipeline's instruction-fetch stage and data-memory stage. It accepts one request per port, picks a winner, and drives a variable-latency memory with a req/ready handshake. It returns read data and a one-cycle acknowledge to the winning stage, and the pipeline stalls that stage until the acknowledge arrives. It sits between `pipeline_top`'s IF/MEM stages and the memory model.

## Interface
Parameters:
- `AW`, 32, address width.
- `DW`, 32, data width.
- `STARVE_MAX`, 4, consecutive data grants allowed while fetch waits (guard build only); legal range 1–15.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_req`  in  1  fetch request; held until `i_ack`.
- `i_addr`  in  AW  fetch address.
- `i_rdata`  out  DW  fetch data; valid in the `i_ack` cycle.
- `i_ack`  out  1  one-cycle fetch completion pulse.
- `d_req`  in  1  data request; held until `d_ack`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  AW  data address.
- `d_wdata`  in  DW  store data.
- `d_rdata`  out  DW  load data; valid in the `d_ack` cycle.
- `d_ack`  out  1  one-cycle data completion pulse.
- `m_req`  out  1  memory request.
- `m_we`  out  1  memory write enable.
- `m_addr`  out  AW  memory address.
- `m_wdata`  out  DW  memory write data.
- `m_rdata`  in  DW  memory read data; valid when `m_ready`=1.
- `m_ready`  in  1  memory completion; sampled only while `m_req`=1.
- `owner`  out  2  00 idle, 01 fetch, 10 data.

## Operation
- FSM states: IDLE, MEM_I, MEM_D, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Otherwise pick a winner. Latch its addr, and for data also `we`/`wdata`, into the `m_*` registers. Go to MEM_I or MEM_D.
- Priority: data beats fetch, so an older instruction cannot deadlock behind a younger fetch.
- MEM_x:
  - `m_req`=1 and all `m_*` outputs are held stable.
  - When `m_ready`=1, capture `m_rdata` into the winner's rdata register, and only for loads and fetches. Stores leave `d_rdata` unchanged.
  - Then go to RESP.
- RESP:
  - Winner's ack=1 for exactly this cycle. `m_req`=0 and `m_we`=0.
  - Requests are not sampled. Next state is always IDLE, so the requester can drop or change its request first.
- `owner` tracks state: MEM_I and RESP-after-fetch give 01; MEM_D and RESP-after-data give 10; IDLE gives 00.
- Request inputs are ignored outside IDLE. A requester that drops its req mid-transaction still receives its ack.

## Timing
- Reset value of every output is 0: `i_rdata`, `d_rdata`, `i_ack`, `d_ack`, all `m_*` outputs, `owner`. State resets to IDLE; starvation counter resets to 0.
- Minimum latency:
  - Request seen in IDLE at cycle 0, `m_req` at cycle 1.
  - If `m_ready`=1 at cycle 1, ack at cycle 2 and IDLE again at cycle 3.
  - Peak rate is one access per 3 cycles; each memory wait cycle adds 1.
- Simultaneous `i_req` and `d_req` in IDLE: data is granted and fetch waits. Fetch is granted at the next IDLE in which `d_req`=0, or by the starvation guard.
- `m_ready` while `m_req`=0: ignored.
- Reset mid-transaction: `m_req` drops at the next edge, no ack is issued, and the transaction is abandoned.

## Configuration
- `ARB_STARVE_GUARD_EN` defined:
  - A 4-bit counter increments on each data grant made while `i_req`=1.
  - When the counter equals `STARVE_MAX` and `i_req`=1, the next arbitration grants fetch regardless of `d_req`, and the counter clears.
  - The counter also clears on any fetch grant, and at any arbitration with `i_req`=0.
- Not defined: no counter; strict data-over-fetch priority.

## Test plan
- Reset, then `i_req`=1 with `i_addr`=0x0000_0010, memory returning 0xDEAD_BEEF with zero wait: `m_req` high at cycle 1, `i_ack`=1 with `i_rdata`=0xDEAD_BEEF at cycle 2, `owner` back to 00 at cycle 3.
- Store with `d_addr`=0x100 and `d_wdata`=0x1234_5678, `m_ready` delayed 3 cycles: `m_we`=1 and `m_addr`/`m_wdata` stable for 4 cycles; `d_ack` one cycle later; `d_rdata` unchanged.
- `i_req` and `d_req` raised in the same cycle: MEM_D first, `d_ack` at cycle 2, then fetch granted at cycle 3 with `i_ack` at cycle 5.
- `d_req` held continuously, `i_req` held, guard build with `STARVE_MAX`=4: 4 data acks, then 1 fetch ack, repeating. Non-guard build: fetch never acked until `d_req` drops.
- `rst` asserted during MEM_D with `m_ready`=0: after the edge, `m_req`=0, `owner`=00, and no `d_ack` appears.
- `m_ready`=1 pulsed while IDLE with no request: no state change and no ack.
